wb_gpio_in: RTL and testbench

//  Wishbone responder that samples board inputs (KEY, SW), synchronises and

---
 rtl/wb_gpio_in_pkg.sv | 20 ++
 rtl/wb_if.sv | 32 +++
 rtl/wb_gpio_in_debounce.sv | 62 ++++++
 rtl/wb_gpio_in.sv | 112 +++++++++++
 tb/tb_wb_gpio_in.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_gpio_in_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wb_gpio_in_pkg                                              |
// | Brief  : Register offsets and byte-lane helper for wb_gpio_in        |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package wb_gpio_in_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_EDGE   = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;
    localparam logic [1:0] REG_RAW    = 2'd3;

    // Expand the four Wishbone byte selects into a 32-bit write mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wb_if                                                       |
// | Brief  : Pipelined Wishbone bus bundle with master/slave modports    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface wb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        input  clk, rst, dat_s, ack, stall, err,
        output cyc, stb, we, adr, sel, dat_m
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, stall, err
    );
endinterface
`default_nettype wire

// File: rtl/wb_gpio_in_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : input_debounce                                              |
// | Brief  : N-bit synchroniser, shared tick prescaler, 2-sample filter  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module input_debounce #(
    parameter int             N               = 1,
    parameter logic [N-1:0]   INVERT          = '0,
    parameter int             DEBOUNCE_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    output logic [N-1:0] raw,
    output logic [N-1:0] data,
    output logic [N-1:0] rise
);
    localparam int              c_cnt_w = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]       r_sync1;
    logic [N-1:0]       r_raw;
    logic [N-1:0]       r_s1;
    logic [N-1:0]       r_data;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_tick;
    logic [N-1:0]       w_data_next;

    assign w_tick = (r_cnt == c_cnt_last);

    // A bit only moves when the current raw level matches the previous tick sample.
    always_comb begin
        w_data_next = r_data;
        if (w_tick) begin
            w_data_next = (r_data & (r_raw ^ r_s1)) | (r_s1 & ~(r_raw ^ r_s1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_raw   <= '0;
            r_s1    <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din ^ INVERT;
            r_raw   <= r_sync1;
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_data  <= w_data_next;
            if (w_tick) begin
                r_s1 <= r_raw;
            end
        end
    end

    assign raw  = r_raw;
    assign data = r_data;
    assign rise = w_data_next & ~r_data;
endmodule
`default_nettype wire

// File: rtl/wb_gpio_in.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wb_gpio_in                                                  |
// | Brief  : Wishbone responder for debounced inputs with edge IRQ       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module wb_gpio_in
    import wb_gpio_in_pkg::*;
#(
    parameter int           N               = 1,
    parameter logic [N-1:0] INVERT          = '0,
    parameter int           DEBOUNCE_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         rst,
    wb_if.slave          wb,
    input  logic [N-1:0] din,
    output logic         irq
);
    logic [N-1:0] w_raw;
    logic [N-1:0] w_data;
    logic [N-1:0] w_rise;

    logic         w_accept;
    logic         w_write;
    logic [1:0]   w_reg;
    logic [31:0]  w_lane_mask;
    logic [N-1:0] w_wdata;
    logic [N-1:0] w_edge_next;
    logic [N-1:0] w_en_next;
    logic [31:0]  w_rdata;

    logic [N-1:0] r_edge;
    logic [N-1:0] r_en;
    logic         r_irq;
    logic         r_ack;
    logic [31:0]  r_dat;

    input_debounce #(
        .N               (N),
        .INVERT          (INVERT),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .raw  (w_raw),
        .data (w_data),
        .rise (w_rise)
    );

    assign w_accept    = wb.cyc & wb.stb;
    assign w_write     = w_accept & wb.we;
    assign w_reg       = wb.adr[3:2];
    assign w_lane_mask = lane_mask(wb.sel);
    assign w_wdata     = wb.dat_m[N-1:0];

    always_comb begin
        w_edge_next = r_edge;
        w_en_next   = r_en;
        if (w_write && (w_reg == REG_EDGE)) begin
            w_edge_next = r_edge & ~w_wdata;
        end
        // New rising edges override a same-cycle write-one-to-clear.
        w_edge_next = w_edge_next | w_rise;
        if (w_write && (w_reg == REG_IRQ_EN)) begin
            w_en_next = (r_en & ~w_lane_mask[N-1:0]) | (w_wdata & w_lane_mask[N-1:0]);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_DATA:   w_rdata = 32'(w_data);
            REG_EDGE:   w_rdata = 32'(r_edge);
            REG_IRQ_EN: w_rdata = 32'(r_en);
            REG_RAW:    w_rdata = 32'(w_raw);
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge <= '0;
            r_en   <= '0;
            r_irq  <= 1'b0;
            r_ack  <= 1'b0;
            r_dat  <= '0;
        end else begin
            r_edge <= w_edge_next;
            r_en   <= w_en_next;
            r_irq  <= |(w_edge_next & w_en_next);
            r_ack  <= w_accept;
            r_dat  <= (w_accept && !wb.we) ? w_rdata : '0;
        end
    end

    assign wb.ack   = r_ack;
    assign wb.dat_s = r_dat;
    assign wb.stall = 1'b0;
    assign wb.err   = 1'b0;
    assign irq      = r_irq;

    logic w_unused_adr;
    assign w_unused_adr = ^{wb.adr[31:4], wb.adr[1:0]};

    if (N < 32) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^{wb.dat_m[31:N], w_lane_mask[31:N]};
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_in.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_wb_gpio_in                                               |
// | Brief  : Scoreboard bench for wb_gpio_in against a behavioural model |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_wb_gpio_in;
    localparam int         N   = 4;
    localparam logic [3:0] INV = 4'b0001;
    localparam int         D   = 8;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = '0;
    logic       irq;
    bit         mon_en = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    wb_if bus (.clk(clk), .rst(rst));

    wb_gpio_in #(
        .N               (N),
        .INVERT          (INV),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus),
        .din (din),
        .irq (irq)
    );

    always #5 clk = ~clk;

    // Reference model: levels, tick schedule and registers recomputed every edge.
    exp_t       q[$];
    int         m_cycle;
    logic [3:0] m_sync, m_raw, m_s1, m_data, m_edge, m_en;
    logic       m_irq;

    always @(posedge clk) begin
        exp_t       e;
        logic [3:0] nd, rise, clr;
        if (rst) begin
            m_cycle = 0;
            m_sync = '0; m_raw = '0; m_s1 = '0;
            m_data = '0; m_edge = '0; m_en = '0; m_irq = 1'b0;
            q.delete();
        end else begin
            if (bus.cyc && bus.stb) begin
                e.is_rd = !bus.we;
                case (bus.adr[3:2])
                    2'd0:    e.data = {28'b0, m_data};
                    2'd1:    e.data = {28'b0, m_edge};
                    2'd2:    e.data = {28'b0, m_en};
                    default: e.data = {28'b0, m_raw};
                endcase
                q.push_back(e);
            end
            nd = m_data;
            if ((m_cycle % D) == D - 1) begin
                for (int i = 0; i < N; i++)
                    if (m_raw[i] == m_s1[i]) nd[i] = m_raw[i];
                m_s1 = m_raw;
            end
            rise = nd & ~m_data;
            clr  = (bus.cyc && bus.stb && bus.we && bus.adr[3:2] == 2'd1) ? bus.dat_m[3:0] : 4'b0;
            m_edge = (m_edge & ~clr) | rise;
            if (bus.cyc && bus.stb && bus.we && bus.adr[3:2] == 2'd2)
                for (int i = 0; i < N; i++)
                    if (bus.sel[i / 8]) m_en[i] = bus.dat_m[i];
            m_data = nd;
            m_irq  = |(m_edge & m_en);
            m_raw  = m_sync;
            m_sync = din ^ INV;
            m_cycle++;
        end
    end

    // Monitor: every accepted request must be answered on the very next cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            compared++;
            if (bus.stall !== 1'b0 || bus.err !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_err: stall=%b err=%b required 0/0", bus.stall, bus.err);
            end
            compared++;
            if (irq !== m_irq) begin
                mismatched++;
                $display("FAIL irq: got %b required %b at %0t", irq, m_irq, $time);
            end
            if (bus.ack === 1'b1) begin
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL spurious_ack: ack=1 with no request outstanding at %0t", $time);
                end else begin
                    e = q.pop_front();
                    if (e.is_rd && bus.dat_s !== e.data) begin
                        mismatched++;
                        $display("FAIL read_data: got 0x%08h required 0x%08h at %0t", bus.dat_s, e.data, $time);
                    end
                end
            end else begin
                compared++;
                if (bus.dat_s !== 32'h0) begin
                    mismatched++;
                    $display("FAIL idle_dat: got 0x%08h required 0x00000000 at %0t", bus.dat_s, $time);
                end
            end
            if (q.size() != 0) begin
                compared++;
                mismatched++;
                $display("FAIL missing_ack: %0d request(s) unanswered at %0t", q.size(), $time);
                q.delete();
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.cyc = 1'b0;
            bus.stb = 1'b0;
            bus.we  = 1'b0;
        end
    endtask

    task automatic op(input bit we, input logic [1:0] r, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] a;
        @(negedge clk);
        a       = $urandom();
        a[3:2]  = r;
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = we;
        bus.adr = a;
        bus.dat_m = d;
        bus.sel = sel;
    endtask

    initial begin
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.adr = '0; bus.dat_m = '0; bus.sel = '0;
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        idle(2);
        rst = 1'b0;

        // Reset values of every register, issued back to back.
        for (int r = 0; r < 4; r++) op(1'b0, 2'(r), 32'h0, 4'hF);
        idle(2);

        // Held level debounces and latches an edge.
        din[1] = 1'b1;
        idle(20);
        op(1'b0, 2'd0, 32'h0, 4'hF);
        op(1'b0, 2'd1, 32'h0, 4'hF);
        idle(2);

        // Short pulse is filtered out.
        din[2] = 1'b1;
        idle(5);
        din[2] = 1'b0;
        idle(20);
        op(1'b0, 2'd0, 32'h0, 4'hF);
        op(1'b0, 2'd1, 32'h0, 4'hF);
        idle(2);

        // Interrupt enable, then acknowledge by clearing the edge.
        op(1'b1, 2'd2, 32'h2, 4'hF);
        idle(3);
        op(1'b1, 2'd1, 32'h2, 4'hF);
        idle(2);
        op(1'b0, 2'd1, 32'h0, 4'hF);
        idle(2);

        // Keep clearing bit 1 until a new edge lands in the same cycle as a clear.
        din[1] = 1'b0;
        idle(30);
        din[1] = 1'b1;
        for (int k = 0; k < 40 && !m_edge[1]; k++) op(1'b1, 2'd1, 32'h2, 4'hF);
        idle(1);
        op(1'b0, 2'd1, 32'h0, 4'hF);
        idle(2);

        // Masked write and write to a read-only register.
        op(1'b1, 2'd2, 32'hF, 4'h0);
        op(1'b0, 2'd2, 32'h0, 4'hF);
        op(1'b1, 2'd0, 32'hF, 4'hF);
        op(1'b0, 2'd0, 32'h0, 4'hF);
        idle(2);

        // Reset while a read is being strobed.
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h4;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.cyc = 1'b0; bus.stb = 1'b0;
        for (int r = 0; r < 4; r++) op(1'b0, 2'(r), 32'h0, 4'hF);
        idle(2);

        // Randomised traffic with slow input changes and rare resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) din[$urandom_range(0, 3)] ^= 1'b1;
            rst       = ($urandom_range(0, 299) == 0);
            bus.cyc   = ($urandom_range(0, 3) != 0);
            bus.stb   = ($urandom_range(0, 2) != 0);
            bus.we    = $urandom_range(0, 1);
            bus.adr   = $urandom();
            bus.dat_m = $urandom();
            bus.sel   = 4'($urandom_range(0, 15));
        end
        rst = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
